// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//
// Bundles the operand side and result side of alu_seq into one interface.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high on that edge. The producer holds its payload stable while
// valid is high and ready is low. The same rule applies to
// in_valid/in_ready (operands) and to out_valid/out_ready (result).
//
// Signals (WIDTH = operand/result width):
//   in_valid, op[3:0], a, b   operand request from the fetch stage
//   in_ready                  ALU can take a request this cycle
//   out_valid                 result register holds an unconsumed result
//   out_ready                 writeback takes the result this cycle
//   result, cout, zero,
//   overflow, err             registered result and flags
//   busy                      iterative multiply in progress
//
// Modports:
//   master - the side that drives operands and consumes results
//   slave  - the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, zero, overflow, err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, zero, overflow, err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//
// Registered WIDTH-bit ALU sitting between operand fetch and writeback.
// Op set: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR,
//         8 MUL (optional), everything else illegal (result 0, err 1).
// Single-cycle ops write the one-entry output register on the accepting
// edge. MUL runs a WIDTH-step shift-add and writes the register on its
// last step.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   - op 8 is an unsigned multiply (low half to result, overflow
//               set when the high half is nonzero); the FSM has a MUL state.
//   undefined - no multiplier hardware; op 8 is illegal and busy is 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        alu_seq_if.slave (handshakes, operands, result, flags, busy)
//   state_dbg  current FSM state (0 IDLE, 1 MUL) for observation
//
// Handshake: a transfer occurs on a rising edge when valid && ready. Inputs
// a, b and op are sampled only on an accepting edge. The result and flags
// stay stable while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus,
    output logic     state_dbg
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam int         CW      = $clog2(WIDTH) + 1;
`endif

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

    state_t state;
    state_t state_n;

    // Output register contents.
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             overflow_q;
    logic             err_q;

    logic in_ready_i;
    logic accept;
    logic start_mul;
    logic write_single;

    // ------------------------------------------------------------------
    // Handshake. in_ready is forced low during reset so nothing upstream
    // sees a ready window while the block is being cleared.
    // ------------------------------------------------------------------
    assign in_ready_i = rst_n && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_i;

`ifdef ALU_SEQ_MUL_EN
    assign start_mul = accept && (bus.op == OP_MUL);
`else
    assign start_mul = 1'b0;
`endif
    assign write_single = accept && !start_mul;

    // ------------------------------------------------------------------
    // Single-cycle datapath. SUB and SLT share the adder with b inverted
    // and a carry-in of one.
    // ------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;

    assign is_sub  = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    assign b_eff   = is_sub ? ~bus.b : bus.b;
    assign sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // Signed overflow: operands agree in sign but the sum does not.
    assign sum_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.a[WIDTH-1]);

    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = sum_ovf;
            end
            OP_XOR:  alu_res = bus.a ^ bus.b;
            // Signed less-than: sign of the difference, corrected when
            // the subtraction overflowed.
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            OP_AND:  alu_res = bus.a & bus.b;
            OP_NAND: alu_res = ~(bus.a & bus.b);
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_OR:   alu_res = bus.a | bus.b;
            // Illegal ops (and MUL, which never uses this path when the
            // multiplier is built).
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier. acc starts as {0, b}; each step adds a to the
    // upper half when the current low bit of the multiplier is set, then
    // shifts the whole accumulator right by one. After WIDTH steps acc
    // holds the full 2*WIDTH-bit product.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     hi_sum;
    logic [CW-1:0]      cnt;
    logic               mul_done;

    assign hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                      (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign acc_next = {hi_sum, acc[WIDTH-1:1]};
    // cnt counts completed steps; the last step is the one where it
    // reads WIDTH-1, so it never needs to reach WIDTH.
    assign mul_done = (state == MUL) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start_mul) begin
            a_q <= bus.a;
            acc <= {{WIDTH{1'b0}}, bus.b};
            cnt <= '0;
        end else if (state == MUL) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
`ifdef ALU_SEQ_MUL_EN
            IDLE:    if (start_mul) state_n = MUL;
            MUL:     if (mul_done)  state_n = IDLE;
`else
            IDLE:    state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register. Written on a single-cycle accept or on the final
    // multiply step; otherwise a consume simply clears out_valid. A MUL
    // accept frees the slot immediately, so out_valid is low while the
    // multiply runs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (write_single) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            cout_q      <= alu_cout;
            zero_q      <= (alu_res == '0);
            overflow_q  <= alu_ovf;
            err_q       <= alu_err;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= acc_next[WIDTH-1:0];
            cout_q      <= 1'b0;
            zero_q      <= (acc_next[WIDTH-1:0] == '0);
            overflow_q  <= |acc_next[2*WIDTH-1:WIDTH];
            err_q       <= 1'b0;
        end else if (start_mul) begin
            out_valid_q <= 1'b0;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.err       = err_q;
`ifdef ALU_SEQ_MUL_EN
    assign bus.busy      = (state == MUL);
`else
    assign bus.busy      = 1'b0;
`endif
    assign state_dbg     = state;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//
// Directed bench for alu_seq at WIDTH=32. A transaction-level model (plain
// arithmetic on the op definitions plus a handshake/occupancy model) keeps
// the expected result slot in exp_q; a negedge process compares the DUT
// against it every cycle. Literal checks at key points pin the model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W  = 32;
    localparam int EW = W + 4;   // {result, cout, zero, overflow, err}

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic state_dbg;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [EW-1:0] model(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         e;
        longint       sa;
        longint       sb;
        longint       s;
        logic [63:0]  p;
        r  = '0;
        c  = 1'b0;
        o  = 1'b0;
        e  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                r = a + b;
                p = {32'd0, a} + {32'd0, b};
                c = (p > 64'hFFFF_FFFF);
                s = sa + sb;
                o = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                o = (s > SMAX) || (s < SMIN);
            end
            4'd2: r = a ^ b;
            4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4: r = a & b;
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = a | b;
`ifdef ALU_SEQ_MUL_EN
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                o = (p[63:32] != 32'd0);
            end
`endif
            default: e = 1'b1;
        endcase
        return {r, c, (r == '0), o, e};
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op == 4'd8;
`else
        return 1'b0;
`endif
    endfunction

    // exp_q holds the result occupying (or about to occupy) the output slot.
    logic [EW-1:0] exp_q[$];
    int            m_left = 0;   // multiply cycles still to run

    function automatic bit m_in_ready();
        return rst_n && (m_left == 0) && (exp_q.size() == 0 || bus.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.in_valid && m_in_ready()) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(model(bus.op, bus.a, bus.b));
            if (is_mul(bus.op)) m_left = W;
        end else if (bus.out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        bit            m_ov;
        m_ov = (exp_q.size() > 0) && (m_left == 0);
        chk("cyc_in_ready", bus.in_ready, m_in_ready());
        chk("cyc_out_valid", bus.out_valid, m_ov);
        chk("cyc_busy", bus.busy, m_left > 0);
        if (m_ov) begin
            e = exp_q[0];
            chk("cyc_result", bus.result, e[EW-1:4]);
            chk("cyc_cout", bus.cout, e[3]);
            chk("cyc_zero", bus.zero, e[2]);
            chk("cyc_overflow", bus.overflow, e[1]);
            chk("cyc_err", bus.err, e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [3:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        bus.in_valid = v;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_result"}, bus.result, 0);
        chk({tag, "_flags"}, {bus.cout, bus.zero, bus.overflow, bus.err}, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // Logic-op / SLT table with hand-computed results.
    logic [3:0]   t_op  [6] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd3, 4'd3};
    logic [W-1:0] t_a   [6] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'h0F0F_0000,
                                32'h0F0F_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [W-1:0] t_b   [6] = '{32'hFF00_00FF, 32'hFF00_00FF, 32'h0000_F0F0,
                                32'h0000_F0F0, 32'h0000_0001, 32'hFFFF_FFFF};
    logic [W-1:0] t_exp [6] = '{32'hF000_0034, 32'h0FFF_FFCB, 32'hF0F0_0F0F,
                                32'h0F0F_F0F0, 32'h0000_0001, 32'h0000_0000};

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 4'd0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", bus.in_ready, 1);
        cyc();

        // SUB then SLT, 5 and 7
        drive(1, 4'd1, 32'd5, 32'd7);
        cyc();
        chk("sub_result", bus.result, 32'hFFFF_FFFE);
        chk("sub_flags", {bus.cout, bus.overflow, bus.zero, bus.err}, 4'b0000);
        drive(1, 4'd3, 32'd5, 32'd7);
        cyc();
        chk("slt_result", bus.result, 32'd1);
        chk("slt_valid", bus.out_valid, 1);

        // ADD overflow and carry cases
        drive(1, 4'd0, 32'h7FFF_FFFF, 32'd1);
        cyc();
        chk("add_ovf_result", bus.result, 32'h8000_0000);
        chk("add_ovf_flags", {bus.overflow, bus.cout}, 2'b10);
        drive(1, 4'd0, 32'hFFFF_FFFF, 32'd1);
        cyc();
        chk("add_carry_result", bus.result, 32'd0);
        chk("add_carry_flags", {bus.cout, bus.zero, bus.overflow}, 3'b110);

        // SUB signed overflow, no borrow
        drive(1, 4'd1, 32'h8000_0000, 32'd1);
        cyc();
        chk("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", {bus.overflow, bus.cout}, 2'b11);

        for (int i = 0; i < 6; i++) begin
            drive(1, t_op[i], t_a[i], t_b[i]);
            cyc();
            chk("table_result", bus.result, t_exp[i]);
        end

        // Back-to-back XOR with backpressure
        drive(1, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        cyc();
        chk("xor1_result", bus.result, 32'hFF00_FF00);
        bus.out_ready = 1'b0;
        drive(1, 4'd2, 32'h1234_5678, 32'h1234_5678);
        #1;
        chk("xor_in_ready_drop", bus.in_ready, 0);
        cyc();
        chk("xor1_held", bus.result, 32'hFF00_FF00);
        cyc();
        chk("xor1_held2", bus.result, 32'hFF00_FF00);
        bus.out_ready = 1'b1;
        #1;
        chk("xor_in_ready_back", bus.in_ready, 1);
        cyc();
        chk("xor2_valid", bus.out_valid, 1);
        chk("xor2_result", {bus.result, bus.zero}, {32'd0, 1'b1});
        drive(1, 4'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        cyc();
        chk("xor3_result", bus.result, 32'h5555_5555);
        drive(0, 4'd0, '0, '0);
        cyc();

        // Illegal op
        drive(1, 4'd11, 32'h1234, 32'h5678);
        cyc();
        chk("illegal_result", bus.result, 32'd0);
        chk("illegal_flags", {bus.err, bus.zero, bus.cout, bus.overflow}, 4'b1100);
        drive(0, 4'd0, '0, '0);
        cyc();

`ifdef ALU_SEQ_MUL_EN
        drive(1, 4'd8, 32'h0001_0000, 32'h0001_0001);
        cyc();
        chk("mul_busy_start", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
        // Held request during the multiply must be ignored.
        drive(1, 4'd0, 32'd1, 32'd1);
        repeat (31) cyc();
        chk("mul_busy_last", bus.busy, 1);
        cyc();
        chk("mul1_done", {bus.busy, bus.out_valid}, 2'b01);
        chk("mul1_result", bus.result, 32'h0001_0000);
        chk("mul1_overflow", bus.overflow, 1);
        drive(1, 4'd8, 32'd3, 32'd5);
        cyc();
        drive(0, 4'd0, '0, '0);
        for (int i = 0; i < 40 && !bus.out_valid; i++) cyc();
        chk("mul2_done", bus.out_valid, 1);
        chk("mul2_result", bus.result, 32'd15);
        chk("mul2_overflow", bus.overflow, 0);
        cyc();

        // Reset in the middle of a multiply
        drive(1, 4'd8, 32'hFFFF, 32'hFFFF);
        cyc();
        drive(0, 4'd0, '0, '0);
        repeat (9) cyc();
        chk("mul_busy_before_reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_mul_reset");
`else
        drive(1, 4'd8, 32'd3, 32'd5);
        cyc();
        chk("mul_off_result", bus.result, 32'd0);
        chk("mul_off_flags", {bus.err, bus.zero, bus.busy}, 3'b110);
        drive(1, 4'd0, 32'd1, 32'd2);
        bus.out_ready = 1'b0;
        cyc();
        drive(0, 4'd0, '0, '0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk_all_zero("held_reset");
`endif
        cyc();
        cyc();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_after_rerelease", bus.in_ready, 1);
        repeat (40) cyc();
        chk("no_stale_out_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 32-bit combinational ALU. Keeps the 3-bit op set (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR) and its flags (cout, zero, overflow), generalised to WIDTH bits. Adds a valid/ready handshake on both sides, a one-entry output register, and an iterative shift-add multiply. Sits between the CPU operand-fetch stage and the writeback stage.

## Interface
- WIDTH, 32, operand and result width in bits; minimum 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts on this cycle's edge if in_valid is high.
- op  in  4  0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT, 0100 AND, 0101 NAND, 0110 NOR, 0111 OR, 1000 MUL, 1001–1111 illegal.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result on this cycle's edge.
- result  out  WIDTH  registered result.
- cout, zero, overflow, err  out  1 each  registered flags.
- busy  out  1  multiply in progress.

## Operation
- States: IDLE, MUL. Reset state is IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready at a rising edge; a, b and op are sampled only then.
- ADD: result = a+b. cout = carry out of bit WIDTH-1. overflow = signed overflow.
- SUB: result = a + ~b + 1. cout = carry out (1 means no borrow). overflow = signed overflow.
- SLT: result = {0…0, (a<b) signed}. Computed as sub_msb XOR sub_overflow. cout = overflow = 0.
- Logic ops: bitwise; cout = overflow = 0.
- MUL: result = low WIDTH bits of unsigned a*b. overflow = 1 if the high WIDTH bits are nonzero. cout = 0. Computed by a WIDTH-iteration shift-add with a 2·WIDTH accumulator.
- Illegal op: result = 0, cout = overflow = 0, err = 1. err is 0 for every legal op.
- zero = (result == 0) for every op, including illegal (so zero = 1 there).
- Output register updates only on accept (single-cycle ops) or on MUL completion.
- result and flags are held stable while out_valid && !out_ready.
- out_valid clears on an edge with out_ready high, unless a new result is written on the same edge.

## Timing
- Reset (rst_n low, asynchronous): out_valid, result, cout, zero, overflow, err, busy = 0. State goes to IDLE and the accumulator and counter clear. in_ready = 0 while rst_n is low and 1 in the first cycle after release.
- Single-cycle op accepted at edge E: out_valid = 1 after E. With out_ready held high, throughput is one op per cycle.
- MUL accepted at edge E:
  - busy = 1 and in_ready = 0 from after E until edge E+WIDTH.
  - out_valid = 0 during the multiply; the output slot was freed at E.
  - After edge E+WIDTH: result valid, out_valid = 1, busy = 0, state IDLE.
- Simultaneous consume and accept on the same edge: the old result is dropped and the new one is written. out_valid stays 1.
- rst_n asserted mid-MUL: the partial product is discarded and no result is ever emitted.
- in_valid low, or in_ready low: inputs are ignored.
- The counter is $clog2(WIDTH)+1 bits and does not wrap within one op.

## Configuration
- ALU_SEQ_MUL_EN defined: op 1000 is MUL as described, and the state machine includes the MUL state.
- ALU_SEQ_MUL_EN undefined: no multiplier, accumulator or counter is built. Op 1000 is treated as illegal (result 0, err 1, single-cycle), and busy is tied to 0.

## Test plan
- WIDTH=32, op SUB, a=5, b=7, out_ready=1 → next cycle result=0xFFFFFFFE, cout=0, overflow=0, zero=0. Then SLT with the same operands → result=1.
- op ADD, a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, cout=0. Then a=0xFFFFFFFF, b=1 → result=0, cout=1, zero=1.
- Back-to-back XOR on 3 consecutive cycles with out_ready=0 from the second cycle:
  - in_ready drops after the first accept.
  - The first result is held unchanged.
  - Raising out_ready gives a simultaneous consume and accept with out_valid staying 1.
- MUL (macro on), a=0x10000, b=0x10001 → busy for 32 cycles, then result=0x00010000, overflow=1. a=3, b=5 → result=15, overflow=0. in_valid during busy is not accepted.
- op 1011 → result=0, err=1, zero=1. With the macro off, op 1000 → err=1 after 1 cycle.
- rst_n pulsed low at cycle 10 of a MUL → all outputs 0 immediately. No out_valid follows, and in_ready=1 after release.
